uart_rx_frame: RTL and testbench
================================

# uart_rx_frame

UART receive framer: oversamples the asynchronous serial input, recovers 8-bit frames with optional parity, and presents each byte on an 8-bit AXI-Stream source that feeds the register block's RDR sink (`s_axis_rdr`). It also produces the single-cycle error pulses that drive the register block's `i_isr` parity-error, framing-error and overrun bits. Baud divisor and frame format come from the register block's BRR/CR outputs.

## Interface
Parameters:
- `BRR_W`, default 16: width of the baud divisor input.

Ports:
- `clk`  input  1  system clock.
- `rst`  input  1  reset; asynchronous, active-high.
- `i_en`  input  1  receiver enable (from CR1).
- `i_brr`  input  BRR_W  clock cycles per bit; values below 16 are treated as 16.
- `i_pce`  input  1  parity enable.
- `i_ps`  input  1  parity select: 0 = even, 1 = odd.
- `i_rxd`  input  1  asynchronous serial line, idle high.
- `m_axis_rdr`  taxi_axis_if.src  DATA_W=8  received byte; drives tdata, tvalid and tlast (tlast tied 1). tready comes from the RDR sink.
- `o_pe`  output  1  parity error pulse.
- `o_fe`  output  1  framing error pulse.
- `o_ore`  output  1  overrun pulse.
- `o_busy`  output  1  high while the FSM is not in IDLE.

## Operation
- `i_rxd` passes through a 2-FF synchronizer. The falling-edge detector compares the synchronized value with the previous synchronized sample.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE -> START on a falling edge while `i_en`=1. The bit counter loads `brr_eff/2` (floor).
  - START: when the counter expires, sample the line. If low -> DATA. If high -> IDLE (false start; no error, no output).
  - DATA: one sample every `brr_eff` cycles, 8 bits, LSB first, shifted into the shift register. After bit 7 -> PARITY if `i_pce`=1, else STOP.
  - PARITY: sample the parity bit. Mismatch with even/odd parity over the 8 data bits sets a pending PE. Then -> STOP.
  - STOP: sample the stop bit. Low sets a pending FE. Then -> IDLE in the same cycle as the frame completes.
- Frame completion, in the stop-sample cycle:
  - Holding register empty (tvalid=0): load byte, set tvalid. The byte is delivered even when PE or FE is pending.
  - Holding register full (tvalid=1 and no tready that cycle): pulse `o_ore`. The new byte is dropped and the old byte is kept.
  - Holding register full but tready=1 that same cycle: the old byte is consumed and the new byte is loaded. No overrun.
  - `o_pe` and `o_fe` pulse in the completion cycle, independent of overrun.
- Output handshake: tvalid stays high and tdata stays stable until tready=1. tvalid clears in the cycle after the handshake, unless a new byte loads in that same cycle.
- `i_en`=0 forces the FSM to IDLE on the next edge (synchronous abort, no pulses). The holding register and tvalid are unaffected.
- Changes to `i_brr`, `i_pce` or `i_ps` in mid-frame are undefined. Software changes them only while `o_busy`=0.

## Timing
- Reset values:
  - tvalid=0, tdata=0x00.
  - `o_pe`, `o_fe`, `o_ore`, `o_busy` = 0.
  - FSM in IDLE, counters 0.
  - Synchronizer flops = 1, so reset does not produce a false edge.
- Reset asserted in mid-frame clears everything immediately, without waiting for a clock edge. The partial frame is lost.
- Latency from the pin falling edge to tvalid: 2 (sync) + 1 (edge) + `brr_eff/2` + 8·`brr_eff` + `i_pce`·`brr_eff` + `brr_eff` + 1 cycles.
  - Example: BRR=16, no parity gives 156 cycles.
  - Add 1 cycle when `UART_RX_MAJORITY_EN` is defined.
- Error pulses are exactly 1 cycle wide. They coincide with the cycle in which tvalid rises, or would have risen.
- Back-to-back frames are supported: a new start edge is accepted in the cycle after STOP exits.

## Configuration
- `UART_RX_MAJORITY_EN` defined:
  - Every bit (start, data, parity, stop) is decided by a 2-of-3 majority of samples taken at mid-1, mid and mid+1.
  - The decision is made at mid+1, so each sample point shifts by one cycle.
- Not defined: single sample at mid-bit. Lower area, no glitch filtering.

## Test plan
- BRR=16, no parity, serial 0xA5 with tready=1 -> tdata=0xA5, tvalid high for 1 cycle, 156 cycles after the edge. No error pulses.
- BRR=16, `i_pce`=1, `i_ps`=0, send 0x3C with parity bit 1 (wrong) -> `o_pe` 1-cycle pulse, tdata=0x3C delivered. With parity bit 0 -> no pulse.
- Send 0x55 with stop bit held low -> `o_fe` pulse, tdata=0x55. The next valid frame 0x12 is received correctly.
- tready=0, send 0x11 then 0x22 -> `o_ore` pulse at the second stop sample. tdata stays 0x11. After tready=1, tvalid drops and no 0x22 appears.
- Line low for 4 cycles, then high (BRR=16) -> returns to IDLE, no tvalid, no pulses. Reset asserted at bit 4 of a frame -> all outputs 0 immediately; the next full frame is received correctly.
- Macro defined: 1-cycle high glitch at the mid-point of data bit 3 of frame 0x00 -> tdata=0x00. Macro undefined: same stimulus -> tdata=0x08.

Source files
------------

// File: rtl/taxi_axis_if.sv
// AXI-Stream link bundle (tdata/tvalid/tready/tlast).
// src drives data toward the sink; snk returns tready.
interface taxi_axis_if #(
   parameter int DATA_W = 8
) ();
   logic [DATA_W-1:0] tdata;
   logic              tvalid;
   logic              tready;
   logic              tlast;

   modport src (
      output tdata,
      output tvalid,
      output tlast,
      input  tready
   );

   modport snk (
      input  tdata,
      input  tvalid,
      input  tlast,
      output tready
   );
endinterface

// File: rtl/uart_rx_frame.sv
// UART receive framer: oversampled 8-bit frames with optional parity,
// delivered on an AXI-Stream source with PE/FE/ORE error pulses.
// Ports: clk, rst (async high), i_en, i_brr (cycles/bit, min 16),
//   i_pce/i_ps (parity enable / odd select), i_rxd (idle high),
//   m_axis_rdr (byte out, tlast=1), o_pe/o_fe/o_ore (1-cycle pulses),
//   o_busy (FSM not idle).
// Option: UART_RX_MAJORITY_EN -> 2-of-3 vote per bit, +1 cycle latency.
module uart_rx_frame #(
   parameter int BRR_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_en,
   input  logic [BRR_W-1:0] i_brr,
   input  logic             i_pce,
   input  logic             i_ps,
   input  logic             i_rxd,
   taxi_axis_if.src         m_axis_rdr,
   output logic             o_pe,
   output logic             o_fe,
   output logic             o_ore,
   output logic             o_busy
);

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP
   } state_t;

   localparam logic [BRR_W-1:0] BRR_MIN = BRR_W'(16);

   state_t           state;
   logic [BRR_W-1:0] cnt;
   logic [2:0]       bcnt;
   logic [7:0]       shreg;
   logic             pe_pend;
   logic [7:0]       tdata_q;
   logic             tvalid_q;

   logic             s1;
   logic             s2;
   logic             prev;

   logic [BRR_W-1:0] brr_eff;
   logic [BRR_W-1:0] brr_m1;
   logic [BRR_W-1:0] start_ld;
   logic             fall;
   logic             tick;
   logic             bit_v;
   logic             take;

   assign brr_eff = (i_brr < BRR_MIN) ? BRR_MIN : i_brr;
   assign brr_m1  = brr_eff - BRR_W'(1);
   assign fall    = prev & ~s2;
   assign tick    = (cnt == '0);
   assign take    = ~tvalid_q | m_axis_rdr.tready;

`ifdef UART_RX_MAJORITY_EN
   logic d1;
   logic d2;

   // Vote over mid-1, mid, mid+1; the start count is one longer so
   // the decision lands at mid+1.
   assign bit_v    = (s2 & d1) | (s2 & d2) | (d1 & d2);
   assign start_ld = (brr_eff >> 1) + BRR_W'(1);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         d1 <= 1'b1;
         d2 <= 1'b1;
      end else begin
         d1 <= s2;
         d2 <= d1;
      end
   end
`else
   assign bit_v    = s2;
   assign start_ld = brr_eff >> 1;
`endif

   // Synchronizer resets to idle-high so reset never fakes an edge.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1   <= 1'b1;
         s2   <= 1'b1;
         prev <= 1'b1;
      end else begin
         s1   <= i_rxd;
         s2   <= s1;
         prev <= s2;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= IDLE;
         cnt      <= '0;
         bcnt     <= '0;
         shreg    <= '0;
         pe_pend  <= 1'b0;
         tdata_q  <= '0;
         tvalid_q <= 1'b0;
         o_pe     <= 1'b0;
         o_fe     <= 1'b0;
         o_ore    <= 1'b0;
      end else begin
         o_pe  <= 1'b0;
         o_fe  <= 1'b0;
         o_ore <= 1'b0;
         if (tvalid_q && m_axis_rdr.tready)
            tvalid_q <= 1'b0;
         if (!i_en) begin
            state <= IDLE;
            cnt   <= '0;
         end else begin
            unique case (state)
               IDLE: begin
                  if (fall) begin
                     state <= START;
                     cnt   <= start_ld;
                  end
               end
               START: begin
                  if (!tick) begin
                     cnt <= cnt - BRR_W'(1);
                  end else if (!bit_v) begin
                     state   <= DATA;
                     cnt     <= brr_m1;
                     bcnt    <= '0;
                     pe_pend <= 1'b0;
                  end else begin
                     state <= IDLE;
                  end
               end
               DATA: begin
                  if (!tick) begin
                     cnt <= cnt - BRR_W'(1);
                  end else begin
                     shreg <= {bit_v, shreg[7:1]};
                     cnt   <= brr_m1;
                     bcnt  <= bcnt + 3'd1;
                     if (bcnt == 3'd7)
                        state <= i_pce ? PARITY : STOP;
                  end
               end
               PARITY: begin
                  if (!tick) begin
                     cnt <= cnt - BRR_W'(1);
                  end else begin
                     pe_pend <= bit_v ^ (^shreg) ^ i_ps;
                     cnt     <= brr_m1;
                     state   <= STOP;
                  end
               end
               STOP: begin
                  if (!tick) begin
                     cnt <= cnt - BRR_W'(1);
                  end else begin
                     o_fe  <= ~bit_v;
                     o_pe  <= pe_pend;
                     state <= IDLE;
                     cnt   <= '0;
                     // Free or freeing this cycle: load; else drop.
                     if (take) begin
                        tdata_q  <= shreg;
                        tvalid_q <= 1'b1;
                     end else begin
                        o_ore <= 1'b1;
                     end
                  end
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

   assign o_busy            = (state != IDLE);
   assign m_axis_rdr.tdata  = tdata_q;
   assign m_axis_rdr.tvalid = tvalid_q;
   assign m_axis_rdr.tlast  = 1'b1;

endmodule

// File: tb/tb_uart_rx_frame.sv
// Directed bench for uart_rx_frame: latency, parity, framing,
// overrun, false start, async reset, BRR floor and glitch filtering.
module tb_uart_rx_frame;

`ifdef UART_RX_MAJORITY_EN
   localparam int LAT_ADD = 1;
`else
   localparam int LAT_ADD = 0;
`endif

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        i_en = 1'b0;
   logic [15:0] i_brr = 16'd16;
   logic        i_pce = 1'b0;
   logic        i_ps = 1'b0;
   logic        i_rxd = 1'b1;
   logic        o_pe;
   logic        o_fe;
   logic        o_ore;
   logic        o_busy;

   taxi_axis_if #(.DATA_W(8)) rdr ();

   uart_rx_frame #(.BRR_W(16)) dut (
      .clk        (clk),
      .rst        (rst),
      .i_en       (i_en),
      .i_brr      (i_brr),
      .i_pce      (i_pce),
      .i_ps       (i_ps),
      .i_rxd      (i_rxd),
      .m_axis_rdr (rdr.src),
      .o_pe       (o_pe),
      .o_fe       (o_fe),
      .o_ore      (o_ore),
      .o_busy     (o_busy)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc++;

   int       pe_n = 0, fe_n = 0, ore_n = 0;
   int       rise_n = 0, hi_n = 0;
   int       pe_cyc = 0, fe_cyc = 0, ore_cyc = 0;
   int       rise_cyc = 0;
   logic [7:0] rise_data = 8'h00;
   logic     tv_q = 1'b0;

   always @(negedge clk) begin
      if (o_pe) begin pe_n++; pe_cyc = cyc; end
      if (o_fe) begin fe_n++; fe_cyc = cyc; end
      if (o_ore) begin ore_n++; ore_cyc = cyc; end
      if (rdr.tvalid) hi_n++;
      if (rdr.tvalid && !tv_q) begin
         rise_n++;
         rise_cyc = cyc;
         rise_data = rdr.tdata;
      end
      tv_q = rdr.tvalid;
   end

   int n_vec = 0;
   int n_err = 0;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // 16 cycles per bit; glitch flips data bit 3 at its mid sample.
   task automatic send(input logic [7:0] d, input bit pen,
                       input bit pb, input bit sb, input bit glitch,
                       output int t0);
      logic [10:0] b;
      int          n;
      b = '1;
      b[0] = 1'b0;
      b[8:1] = d;
      if (pen) b[9] = pb;
      b[9 + int'(pen)] = sb;
      n = 10 + int'(pen);
      t0 = 0;
      for (int i = 0; i < n; i++) begin
         for (int j = 0; j < 16; j++) begin
            @(negedge clk);
            if (i == 0 && j == 0) t0 = cyc;
            i_rxd = b[i] ^ (glitch && i == 4 && j == 9);
         end
      end
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(negedge clk);
         i_rxd = 1'b1;
      end
   endtask

   int t0, t1;
   int b_rise, b_hi, b_pe, b_fe, b_ore;

   task automatic snap();
      b_rise = rise_n;
      b_hi   = hi_n;
      b_pe   = pe_n;
      b_fe   = fe_n;
      b_ore  = ore_n;
   endtask

   initial begin
      rdr.tready = 1'b1;
      repeat (3) @(negedge clk);
      chk("rst_tvalid", 32'(rdr.tvalid), 0);
      chk("rst_tdata", 32'(rdr.tdata), 0);
      chk("rst_pulses", {29'd0, o_pe, o_fe, o_ore}, 0);
      chk("rst_busy", 32'(o_busy), 0);
      rst = 1'b0;
      i_en = 1'b1;
      idle(5);

      // 0xA5, no parity, tready=1
      snap();
      send(8'hA5, 0, 0, 1, 0, t0);
      idle(10);
      chk("a5_rise", rise_n - b_rise, 1);
      chk("a5_data", 32'(rise_data), 32'hA5);
      chk("a5_lat", rise_cyc - t0, 156 + LAT_ADD);
      chk("a5_hi1", hi_n - b_hi, 1);
      chk("a5_err", (pe_n - b_pe) + (fe_n - b_fe) + (ore_n - b_ore), 0);
      chk("a5_busy", 32'(o_busy), 0);

      // parity: 0x3C even, wrong bit then right bit
      i_pce = 1'b1;
      i_ps = 1'b0;
      snap();
      send(8'h3C, 1, 1, 1, 0, t0);
      idle(10);
      chk("pe_pulse", pe_n - b_pe, 1);
      chk("pe_align", pe_cyc, rise_cyc);
      chk("pe_data", 32'(rise_data), 32'h3C);
      chk("pe_lat", rise_cyc - t0, 172 + LAT_ADD);
      snap();
      send(8'h3C, 1, 0, 1, 0, t0);
      idle(10);
      chk("par_ok_pe", pe_n - b_pe, 0);
      chk("par_ok_rise", rise_n - b_rise, 1);
      chk("par_ok_data", 32'(rise_data), 32'h3C);
      // odd parity: 0x07 has 3 ones, odd bit = 0
      i_ps = 1'b1;
      snap();
      send(8'h07, 1, 0, 1, 0, t0);
      idle(10);
      chk("odd_pe", pe_n - b_pe, 0);
      chk("odd_data", 32'(rise_data), 32'h07);
      i_pce = 1'b0;
      i_ps = 1'b0;

      // framing error then recovery
      snap();
      send(8'h55, 0, 0, 0, 0, t0);
      idle(20);
      chk("fe_pulse", fe_n - b_fe, 1);
      chk("fe_align", fe_cyc, rise_cyc);
      chk("fe_data", 32'(rise_data), 32'h55);
      snap();
      send(8'h12, 0, 0, 1, 0, t0);
      idle(10);
      chk("fe_next_data", 32'(rise_data), 32'h12);
      chk("fe_next_fe", fe_n - b_fe, 0);

      // overrun
      rdr.tready = 1'b0;
      snap();
      send(8'h11, 0, 0, 1, 0, t0);
      idle(10);
      send(8'h22, 0, 0, 1, 0, t1);
      idle(10);
      chk("ore_pulse", ore_n - b_ore, 1);
      chk("ore_cyc", ore_cyc - t1, 156 + LAT_ADD);
      chk("ore_rise", rise_n - b_rise, 1);
      chk("ore_keep", 32'(rdr.tdata), 32'h11);
      chk("ore_valid", 32'(rdr.tvalid), 1);
      rdr.tready = 1'b1;
      @(negedge clk);
      chk("ore_drop", 32'(rdr.tvalid), 0);
      snap();
      idle(20);
      chk("ore_no22", rise_n - b_rise, 0);

      // false start: 4 low cycles
      snap();
      repeat (4) begin
         @(negedge clk);
         i_rxd = 1'b0;
      end
      @(negedge clk);
      i_rxd = 1'b1;
      chk("fs_busy", 32'(o_busy), 1);
      idle(40);
      chk("fs_busy_end", 32'(o_busy), 0);
      chk("fs_rise", rise_n - b_rise, 0);
      chk("fs_err", (pe_n - b_pe) + (fe_n - b_fe) + (ore_n - b_ore), 0);

      // async reset at data bit 4
      fork
         send(8'h5A, 0, 0, 1, 0, t0);
         begin
            repeat (16 * 5 + 5) @(negedge clk);
            #2 rst = 1'b1;
            #1;
            chk("mrst_busy", 32'(o_busy), 0);
            chk("mrst_tdata", 32'(rdr.tdata), 0);
            chk("mrst_tvalid", 32'(rdr.tvalid), 0);
         end
      join
      @(negedge clk);
      rst = 1'b0;
      idle(5);
      snap();
      send(8'h81, 0, 0, 1, 0, t0);
      idle(10);
      chk("mrst_next", 32'(rise_data), 32'h81);
      chk("mrst_rise", rise_n - b_rise, 1);
      chk("mrst_lat", rise_cyc - t0, 156 + LAT_ADD);

      // BRR below floor behaves as 16
      i_brr = 16'd4;
      send(8'h3A, 0, 0, 1, 0, t0);
      idle(10);
      chk("brr_data", 32'(rise_data), 32'h3A);
      chk("brr_lat", rise_cyc - t0, 156 + LAT_ADD);
      i_brr = 16'd16;

      // glitch at mid of data bit 3
      send(8'h00, 0, 0, 1, 1, t0);
      idle(10);
`ifdef UART_RX_MAJORITY_EN
      chk("glitch", 32'(rise_data), 32'h00);
`else
      chk("glitch", 32'(rise_data), 32'h08);
`endif

      $display("== %0d vectors applied, %0d miscompares ==",
               n_vec, n_err);
      $finish;
   end

endmodule
